// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad entry block.
// Key map is indexed {row, col}; element 0 is row 0 / column 0.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-numbered row that reads low wins when several keys share a column.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-clock tick every DIV clocks, count 0..DIV-1.
// Also used by the display refresh logic.
module tick_divider #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner with debounce; accepted keys shift into a 16-bit entry.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SCAN     | rotating the low column each tick, looking for a low row
// PRESS_DB | column frozen, counting ticks the latched row stays low
// HELD     | key accepted, waiting for every row to read high
// REL_DB   | counting all-high ticks before resuming the scan
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] num,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        clear
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DB_DONE = DW'(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  kp_state_e   state, state_d;
  logic [1:0]  col_idx, col_idx_d;
  logic [1:0]  row_lat, row_lat_d;
  logic [DW-1:0] db_cnt, db_cnt_d, db_inc;
  logic [3:0]  row_m, row_s;
  logic        tick;
  logic        any_low;
  logic        accept;
  logic [1:0]  accept_row;
  logic [3:0]  accept_code;
  logic [7:0]  col_rot;

  tick_divider #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Rows come straight off the keypad, so re-time them before any decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign any_low = (row_s != 4'hF);
  assign db_inc  = (db_cnt == DB_DONE) ? db_cnt : db_cnt + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_lat <= 2'd0;
      db_cnt  <= '0;
    end else begin
      state   <= state_d;
      col_idx <= col_idx_d;
      row_lat <= row_lat_d;
      db_cnt  <= db_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    col_idx_d  = col_idx;
    row_lat_d  = row_lat;
    db_cnt_d   = db_cnt;
    accept     = 1'b0;
    accept_row = row_lat;
    if (tick) begin
      case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_d = col_idx + 2'd1;
          end else begin
            row_lat_d = low_row(row_s);
            db_cnt_d  = DB_ONE;
            if (DB_DONE == DB_ONE) begin
              accept     = 1'b1;
              accept_row = low_row(row_s);
              state_d    = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!row_s[row_lat]) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (!any_low) begin
            db_cnt_d = DB_ONE;
            if (DB_DONE == DB_ONE) begin
              state_d   = SCAN;
              col_idx_d = col_idx + 2'd1;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (!any_low) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              state_d   = SCAN;
              col_idx_d = col_idx + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign accept_code = KEY_MAP[{accept_row, col_idx}];

  // Rotating the idle pattern keeps exactly one column low.
  always_comb begin
    col_rot = {COL_IDLE, COL_IDLE} << col_idx;
    col     = col_rot[7:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num       <= 16'h0000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= accept_code;
      if (clear) begin
        num <= 16'h0000;
      end else if (accept) begin
        num <= {num[11:0], accept_code};
      end
    end
  end

endmodule
